spi_tx_sequencer: RTL and testbench

- Frame-level controller for the write-only SPI master. Buffers bytes from a push interface in an internal first-word-fall-through FIFO.
- On a `go` command, holds the master's `start` input high for exactly N bytes, then enforces a minimum chip-select-high gap before the next frame.
- Sits between the SoC peripheral register logic and the SPI master, replacing direct `start`/`data` drive.

---
 rtl/spi_tx_sequencer.sv | 154 +++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sequencer.sv
// Frame-level controller for the write-only SPI master: buffers pushed bytes in a
// first-word-fall-through FIFO and drives the master's start/data for whole frames.
module spi_tx_sequencer #(
  parameter int FifoDepth = 16,
  parameter int LenWidth  = 8,
  parameter int GapCycles = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_valid_i,
  input  logic [7:0]                       wr_data_i,
  output logic                             wr_ready_o,
  input  logic                             flush_i,
  input  logic [LenWidth-1:0]              frame_len_i,
  input  logic                             go_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [$clog2(FifoDepth+1)-1:0]   fifo_level_o,
  output logic                             spi_start_o,
  output logic [7:0]                       spi_data_o,
  input  logic                             spi_next_req_i
);

  localparam int AddrW  = $clog2(FifoDepth);
  localparam int LevelW = $clog2(FifoDepth + 1);
  localparam int GapW   = (GapCycles > 1) ? $clog2(GapCycles) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [7:0]          mem_q [FifoDepth];
  logic [AddrW-1:0]    wrPtr_q, wrPtr_d;
  logic [AddrW-1:0]    rdPtr_q, rdPtr_d;
  logic [LevelW-1:0]   level_q, level_d;
  logic [1:0]          state_q, state_d;
  logic [LenWidth-1:0] remaining_q, remaining_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                req_q;

  logic fifoFull;
  logic flushNow;
  logic pushEn;
  logic consumed;
  logic goBad;

  assign fifoFull = (level_q == LevelW'(FifoDepth));
  assign flushNow = (state_q == StIdle) && flush_i;
  assign pushEn   = wr_valid_i && !fifoFull && !flushNow;
  // The master may hold its request high for many cycles; only the rising edge is a byte.
  assign consumed = (state_q == StXfer) && spi_next_req_i && !req_q;
  assign goBad    = (frame_len_i == '0) || (int'(frame_len_i) > int'(level_q));

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (pushEn) wrPtr_d = wrPtr_q + AddrW'(1);
    if (consumed) rdPtr_d = rdPtr_q + AddrW'(1);
    case ({pushEn, consumed})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase

    if (flushNow) begin
      rdPtr_d = wrPtr_q;
      level_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (go_i) begin
          if (flush_i || goBad) begin
            err_d = 1'b1;
          end else begin
            remaining_d = frame_len_i;
            state_d     = StXfer;
          end
        end
      end
      StXfer: begin
        if (consumed) begin
          remaining_d = remaining_q - LenWidth'(1);
          if (remaining_q == LenWidth'(1)) begin
            state_d = StGap;
            gap_d   = GapW'(GapCycles - 1);
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    start_d = (state_d == StXfer);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      state_q     <= StIdle;
      remaining_q <= '0;
      gap_q       <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_q       <= spi_next_req_i;
    end
  end

  // Storage needs no reset: the level register alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= wr_data_i;
  end

  assign wr_ready_o   = !fifoFull;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign fifo_level_o = level_q;
  assign spi_start_o  = start_q;
  assign spi_data_o   = (level_q == '0) ? 8'h00 : mem_q[rdPtr_q];

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: a vector table for the basic frame and
// rejection cases, then hand-written sequences for wrap, held requests, reset and gap timing.
module tb_spi_tx_sequencer;

  localparam int FifoDepth = 16;
  localparam int LenWidth  = 8;
  localparam int GapCycles = 4;
  localparam int LevelW    = $clog2(FifoDepth + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wrValid = 1'b0;
  logic [7:0] wrData = '0;
  logic wrReady;
  logic flush = 1'b0;
  logic [LenWidth-1:0] frameLen = '0;
  logic go = 1'b0;
  logic busy, done, err;
  logic [LevelW-1:0] level;
  logic spiStart;
  logic [7:0] spiData;
  logic nextReq = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  spi_tx_sequencer #(
    .FifoDepth(FifoDepth), .LenWidth(LenWidth), .GapCycles(GapCycles)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wrValid), .wr_data_i(wrData), .wr_ready_o(wrReady),
    .flush_i(flush), .frame_len_i(frameLen), .go_i(go),
    .busy_o(busy), .done_o(done), .err_o(err), .fifo_level_o(level),
    .spi_start_o(spiStart), .spi_data_o(spiData), .spi_next_req_i(nextReq)
  );

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       fl;
    logic [7:0] len;
    logic       g;
    logic       req;
    logic       eStart;
    logic       eBusy;
    logic       eDone;
    logic       eErr;
    logic       eReady;
    logic [4:0] eLevel;
    logic [7:0] eData;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic fl,
                               input logic [7:0] len, input logic g, input logic req);
    wrValid  = wv;
    wrData   = wd;
    flush    = fl;
    frameLen = len;
    go       = g;
    nextReq  = req;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    checkOutput(name, {31'b0, done}, 32'd1);
    tick();
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
  endtask

  // Launch a frame and consume it one byte per two cycles, checking each head byte;
  // optionally push a fresh byte on every request-low cycle.
  task automatic runFrame(input int len, input logic [7:0] expFirst,
                          input logic pushMore, input logic [7:0] pushFirst);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'(len), 1'b1, 1'b0);
    tick();
    checkOutput("frame start", {31'b0, spiStart}, 32'd1);
    for (int k = 0; k < len; k++) begin
      checkOutput($sformatf("frame byte %0d", k), {24'b0, spiData}, {24'b0, 8'(expFirst + k)});
      applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1);
      tick();
      applyStimulus(pushMore, 8'(pushFirst + k), 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    logic sawDone;
    logic sawErr;

    //                wv  wd     fl  len   go  req  start busy done err rdy lvl  data
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 8'hA5};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 8'hA5};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 8'hA5};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 8'h3C};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 8'h00};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00};

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset start", {31'b0, spiStart}, 32'd0);
    checkOutput("reset busy",  {31'b0, busy},     32'd0);
    checkOutput("reset done",  {31'b0, done},     32'd0);
    checkOutput("reset err",   {31'b0, err},      32'd0);
    checkOutput("reset ready", {31'b0, wrReady},  32'd1);
    checkOutput("reset level", {27'b0, level},    32'd0);
    checkOutput("reset data",  {24'b0, spiData},  32'd0);
    rst = 1'b0;

    // Basic two-byte frame, rejections, and go ignored during the gap
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].fl, vecs[i].len, vecs[i].g, vecs[i].req);
      tick();
      checkOutput($sformatf("vec%0d start", i), {31'b0, spiStart}, {31'b0, vecs[i].eStart});
      checkOutput($sformatf("vec%0d busy", i),  {31'b0, busy},     {31'b0, vecs[i].eBusy});
      checkOutput($sformatf("vec%0d done", i),  {31'b0, done},     {31'b0, vecs[i].eDone});
      checkOutput($sformatf("vec%0d err", i),   {31'b0, err},      {31'b0, vecs[i].eErr});
      checkOutput($sformatf("vec%0d ready", i), {31'b0, wrReady},  {31'b0, vecs[i].eReady});
      checkOutput($sformatf("vec%0d level", i), {27'b0, level},    {27'b0, vecs[i].eLevel});
      checkOutput($sformatf("vec%0d data", i),  {24'b0, spiData},  {24'b0, vecs[i].eData});
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);

    // Request held high for five cycles counts as a single byte
    pushByte(8'h11);
    pushByte(8'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("held req level", {27'b0, level},   32'd1);
    checkOutput("held req data",  {24'b0, spiData}, 32'h22);
    checkOutput("held req start", {31'b0, spiStart}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("held req level end", {27'b0, level}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
    waitDone("held req done");

    // Flush wins over a push and a go in the same cycle
    applyStimulus(1'b1, 8'hEE, 1'b1, 8'd1, 1'b1, 1'b0);
    tick();
    checkOutput("flush level", {27'b0, level},    32'd0);
    checkOutput("flush err",   {31'b0, err},      32'd1);
    checkOutput("flush busy",  {31'b0, busy},     32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();

    // Fill past capacity, then two 16-byte frames across the pointer wrap
    for (int i = 0; i < 17; i++) begin
      pushByte(8'(8'h40 + i));
      if (i == 15) begin
        checkOutput("full ready", {31'b0, wrReady}, 32'd0);
        checkOutput("full level", {27'b0, level},   32'd16);
      end
    end
    checkOutput("overflow level", {27'b0, level},   32'd16);
    checkOutput("overflow head",  {24'b0, spiData}, 32'h40);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    runFrame(16, 8'h40, 1'b1, 8'h80);
    waitDone("wrap frame1 done");
    checkOutput("wrap level", {27'b0, level},   32'd16);
    checkOutput("wrap head",  {24'b0, spiData}, 32'h80);
    runFrame(16, 8'h80, 1'b0, 8'h00);
    waitDone("wrap frame2 done");
    checkOutput("wrap empty", {27'b0, level}, 32'd0);

    // Reset after one of four bytes aborts without a done pulse
    for (int i = 1; i <= 4; i++) pushByte(8'(i));
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd4, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("abort pre level", {27'b0, level},    32'd3);
    checkOutput("abort pre start", {31'b0, spiStart}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort start", {31'b0, spiStart}, 32'd0);
    checkOutput("abort level", {27'b0, level},    32'd0);
    checkOutput("abort busy",  {31'b0, busy},     32'd0);
    checkOutput("abort data",  {24'b0, spiData},  32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort no done", {31'b0, sawDone}, 32'd0);

    // Go held through the gap: ignored, then start rises GapCycles+1 cycles after falling
    pushByte(8'h61);
    pushByte(8'h62);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("gap fell", {31'b0, spiStart}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd1, 1'b1, 1'b0);
    n = 0;
    sawErr = 1'b0;
    while (!spiStart && n < 20) begin
      tick();
      n++;
      if (err) sawErr = 1'b1;
    end
    checkOutput("gap spacing", 32'(n), 32'(GapCycles + 1));
    checkOutput("gap no err",  {31'b0, sawErr}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("gap second head", {24'b0, spiData}, 32'h62);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0);
    waitDone("gap second done");
    checkOutput("gap final level", {27'b0, level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
